// File: rtl/coin_payout.sv
// Change-return payout: ejects Rs10 coins while at least Rs10 is owed, then a single Rs5,
// one coin per level/ack handshake, with a fixed idle gap between coins and an ack timeout.
module coin_payout #(
  parameter int AMT_W   = 4,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             eject_ack,
  output logic             eject_10,
  output logic             eject_5,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [AMT_W-1:0]  ONE      = AMT_W'(1);
  localparam logic [AMT_W-1:0]  TWO      = AMT_W'(2);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, EJECT, GAP, FAULT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      eject_10  <= 1'b0;
      eject_5   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (req_amt != '0) begin
              state     <= EJECT;
              busy      <= 1'b1;
              remaining <= req_amt;
              eject_10  <= (req_amt >= TWO);
              eject_5   <= (req_amt < TWO);
              wait_cnt  <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        EJECT: begin
          if (eject_ack) begin
            // The coin being dropped is whichever line is currently raised.
            remaining <= eject_10 ? (remaining - TWO) : (remaining - ONE);
            eject_10  <= 1'b0;
            eject_5   <= 1'b0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (wait_cnt == WAIT_END) begin
            eject_10 <= 1'b0;
            eject_5  <= 1'b0;
            fault    <= 1'b1;
            state    <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            if (remaining != '0) begin
              eject_10 <= (remaining >= TWO);
              eject_5  <= (remaining < TWO);
              wait_cnt <= '0;
              state    <= EJECT;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_payout.sv
// Directed bench for coin_payout: hand-computed coin sequences, gap timing,
// zero-amount requests, ack timeout fault, ignored inputs and async reset.
module tb_coin_payout;

  localparam int AMT_W   = 4;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic [AMT_W-1:0] req_amt;
  logic             eject_ack;
  logic             eject_10;
  logic             eject_5;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;

  int tests_run = 0;
  int tests_failed = 0;

  coin_payout #(.AMT_W(AMT_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_amt   (req_amt),
    .eject_ack (eject_ack),
    .eject_10  (eject_10),
    .eject_5   (eject_5),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int e10, input int e5, input int bz,
                            input int dn, input int flt, input int rem);
    check({tag, ".eject_10"}, int'(eject_10), e10);
    check({tag, ".eject_5"}, int'(eject_5), e5);
    check({tag, ".busy"}, int'(busy), bz);
    check({tag, ".done"}, int'(done), dn);
    check({tag, ".fault"}, int'(fault), flt);
    check({tag, ".remaining"}, int'(remaining), rem);
  endtask

  // Called just after the edge that raised an eject line. Holds ack low for
  // `delay` cycles, acks, then checks the whole gap. Returns after the gap ends.
  task automatic pay_coin(input string tag, input int is10, input int rem_before,
                          input int delay);
    for (int i = 0; i <= delay; i++) begin
      check_outs({tag, ".eject"}, is10, 1 - is10, 1, 0, 0, rem_before);
      if (i == delay) eject_ack = 1'b1;
      step();
    end
    eject_ack = 1'b0;
    for (int g = 0; g < GAP_CYC; g++) begin
      check_outs({tag, ".gap"}, 0, 0, 1, 0, 0, rem_before - (is10 != 0 ? 2 : 1));
      step();
    end
  endtask

  task automatic start(input int amt);
    req = 1'b1;
    req_amt = AMT_W'(amt);
    step();
    req = 1'b0;
    req_amt = '0;
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    req_amt = '0;
    eject_ack = 1'b0;
    step();
    step();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_outs("idle", 0, 0, 0, 0, 0, 0);

    // 1: amt=3 -> one ten, one five
    start(3);
    pay_coin("t1.c1", 1, 3, 0);
    pay_coin("t1.c2", 0, 1, 2);
    check_outs("t1.done", 0, 0, 0, 1, 0, 0);
    step();
    check_outs("t1.after", 0, 0, 0, 0, 0, 0);
    $display("[TB] payout amt=3 complete");

    // 2: amt=0 -> immediate done, no eject
    start(0);
    check_outs("t2.done", 0, 0, 0, 1, 0, 0);
    step();
    check_outs("t2.after", 0, 0, 0, 0, 0, 0);
    $display("[TB] payout amt=0 complete");

    // 4: amt=4 with ignored second request and a stray ack in the gap
    start(4);
    check_outs("t4.e1", 1, 0, 1, 0, 0, 4);
    req = 1'b1;
    req_amt = AMT_W'(1);
    step();
    req = 1'b0;
    req_amt = '0;
    check_outs("t4.e1b", 1, 0, 1, 0, 0, 4);
    eject_ack = 1'b1;
    step();
    eject_ack = 1'b0;
    check_outs("t4.g1", 0, 0, 1, 0, 0, 2);
    eject_ack = 1'b1;
    step();
    eject_ack = 1'b0;
    check_outs("t4.g2", 0, 0, 1, 0, 0, 2);
    step();
    pay_coin("t4.c2", 1, 2, 1);
    check_outs("t4.done", 0, 0, 0, 1, 0, 0);
    step();
    check_outs("t4.after", 0, 0, 0, 0, 0, 0);
    $display("[TB] payout amt=4 complete");

    // back-to-back: new request accepted in the done cycle
    start(1);
    pay_coin("b2b.c1", 0, 1, 0);
    check_outs("b2b.done", 0, 0, 0, 1, 0, 0);
    start(2);
    pay_coin("b2b.c2", 1, 2, 0);
    check_outs("b2b.done2", 0, 0, 0, 1, 0, 0);
    step();
    $display("[TB] back-to-back payouts complete");

    // 5: amt=15 -> seven tens then one five
    start(15);
    for (int c = 0; c < 7; c++) pay_coin("t5.ten", 1, 15 - 2 * c, c % 3);
    pay_coin("t5.five", 0, 1, 0);
    check_outs("t5.done", 0, 0, 0, 1, 0, 0);
    step();
    $display("[TB] payout amt=15 complete");

    // 3: amt=2 with ack withheld -> fault after TIMEOUT eject cycles
    start(2);
    for (int i = 0; i < TIMEOUT; i++) begin
      check_outs("t3.wait", 1, 0, 1, 0, 0, 2);
      step();
    end
    check_outs("t3.fault", 0, 0, 1, 0, 1, 2);
    start(3);
    check_outs("t3.req_ign", 0, 0, 1, 0, 1, 2);
    eject_ack = 1'b1;
    step();
    step();
    eject_ack = 1'b0;
    check_outs("t3.ack_ign", 0, 0, 1, 0, 1, 2);
    #2;
    reset = 1'b1;
    #1;
    check_outs("t3.reset", 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    check_outs("t3.idle", 0, 0, 0, 0, 0, 0);
    $display("[TB] timeout fault and recovery complete");

    // 6: async reset mid-eject, then a fresh payout
    start(5);
    check_outs("t6.e1", 1, 0, 1, 0, 0, 5);
    #2;
    reset = 1'b1;
    #1;
    check_outs("t6.reset", 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    check_outs("t6.idle", 0, 0, 0, 0, 0, 0);
    start(1);
    pay_coin("t6.c1", 0, 1, 0);
    check_outs("t6.done", 0, 0, 0, 1, 0, 0);
    step();
    check_outs("t6.after", 0, 0, 0, 0, 0, 0);
    $display("[TB] reset mid-payout complete");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
